alu_issue_stage: RTL

//  Decode->execute pipeline register feeding the combinational ALU. Selects and forwards

---
 rtl/alu_issue_stage_pkg.sv | 32 +++
 rtl/alu_issue_stage_if.sv | 57 +++++
 rtl/alu_issue_stage_operand_fwd.sv | 35 +++
 rtl/alu_issue_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared constants for the ALU issue stage: the ALU operation codes
//   (SEL_*) and the operand source selects for x (OPA_*) and y (OPB_*).
//   No ports.
package alu_issue_stage_pkg;

    // ALU operation codes carried through to the ALU unchanged.
    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_AND  = 4'd2;
    localparam logic [3:0] SEL_OR   = 4'd3;
    localparam logic [3:0] SEL_XOR  = 4'd4;
    localparam logic [3:0] SEL_SLL  = 4'd5;
    localparam logic [3:0] SEL_SRL  = 4'd6;
    localparam logic [3:0] SEL_SRA  = 4'd7;
    localparam logic [3:0] SEL_SLT  = 4'd8;
    localparam logic [3:0] SEL_SLTU = 4'd9;

    // x operand source. Code 3 is reserved and selects zero.
    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    // y operand source.
    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } opb_sel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Decode-side and ALU-side bundle of the issue stage.
//   in_*  : instruction from decode (valid/ready, operands, controls)
//   out_* : registered instruction toward the ALU (valid/ready, x/y, passthroughs)
//   modport master : decode + downstream consumer side
//   modport slave  : the issue stage
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A producer holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on valid; valid never depends on ready.
interface alu_issue_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic            in_rs2_used;
    logic [XLEN-1:0] in_imm;
    logic [1:0]      in_opa_sel;
    logic            in_opb_sel;
    logic [3:0]      in_alusel;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic            in_is_load;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_x;
    logic [XLEN-1:0] out_y;
    logic [3:0]      out_alusel;
    logic [XLEN-1:0] out_store_data;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic            out_is_load;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
               in_rs2_used, in_imm, in_opa_sel, in_opb_sel, in_alusel,
               in_rd, in_wen, in_is_load, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_alusel,
               out_store_data, out_pc, out_rd, out_wen, out_is_load
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
               in_rs2_used, in_imm, in_opa_sel, in_opb_sel, in_alusel,
               in_rd, in_wen, in_is_load, out_ready,
        output in_ready, out_valid, out_x, out_y, out_alusel,
               out_store_data, out_pc, out_rd, out_wen, out_is_load
    );

endinterface

// File: rtl/alu_issue_stage_operand_fwd.sv
// alu_issue_stage_operand_fwd
//   Combinational forwarding mux for one source register.
//   rs, regval        : source index and regfile read data
//   ex_wen/ex_rd/ex_is_load/ex_data : instruction in EX
//   wb_wen/wb_rd/wb_data            : writeback stage
//   val               : forwarded operand value
module alu_issue_stage_operand_fwd #(
    parameter int XLEN = 64
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] regval,
    input  logic            ex_wen,
    input  logic [4:0]      ex_rd,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val
);

    // EX is younger than WB, so it wins. A load in EX has no data yet;
    // that case is covered by the load-use stall in the top level.
    always_comb begin
        val = regval;
        if (rs == 5'd0) begin
            val = '0;
        end else if (ex_wen && (ex_rd == rs) && !ex_is_load) begin
            val = ex_data;
        end else if (wb_wen && (wb_rd == rs)) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode->execute pipeline register in front of the combinational ALU.
//   Forwards rs1/rs2 from EX and WB, stalls on load-use, selects x/y and
//   registers them with the passthrough fields.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : kills the registered and the incoming instruction
//   bus (slave)   : in_* from decode, out_* toward the ALU
//   ex_*          : EX-stage destination / result for forwarding and hazard
//   wb_*          : WB-stage destination / data for forwarding
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_issue_stage_if.slave   bus,
    input  logic               ex_wen,
    input  logic [4:0]         ex_rd,
    input  logic               ex_is_load,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               wb_wen,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data
);

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] x_next;
    logic [XLEN-1:0] y_next;
    logic            hazard;
    logic            capture;

    alu_issue_stage_operand_fwd #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs         (bus.in_rs1),
        .regval     (bus.in_rs1_val),
        .ex_wen     (ex_wen),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .ex_data    (ex_data),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .val        (rs1_fwd)
    );

    alu_issue_stage_operand_fwd #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs         (bus.in_rs2),
        .regval     (bus.in_rs2_val),
        .ex_wen     (ex_wen),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .ex_data    (ex_data),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .val        (rs2_fwd)
    );

    // Load-use: rs2 counts whenever it is read, including stores whose y is IMM.
    assign hazard = bus.in_valid && ex_wen && ex_is_load && (ex_rd != 5'd0) &&
                    (((bus.in_opa_sel == OPA_RS1) && (bus.in_rs1 == ex_rd)) ||
                     (((bus.in_opb_sel == OPB_RS2) || bus.in_rs2_used) &&
                      (bus.in_rs2 == ex_rd)));

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !flush && !rst;
    assign capture      = bus.in_valid && bus.in_ready;

    always_comb begin
        x_next = '0;
        case (bus.in_opa_sel)
            OPA_RS1: x_next = rs1_fwd;
            OPA_PC:  x_next = bus.in_pc;
            default: x_next = '0;
        endcase
    end

    assign y_next = (bus.in_opb_sel == OPB_IMM) ? bus.in_imm : rs2_fwd;

    // Priority: reset, flush, capture, bubble, otherwise hold (backpressure).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_x          <= '0;
            bus.out_y          <= '0;
            bus.out_alusel     <= '0;
            bus.out_store_data <= '0;
            bus.out_pc         <= '0;
            bus.out_rd         <= '0;
            bus.out_wen        <= 1'b0;
            bus.out_is_load    <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (capture) begin
            bus.out_valid      <= 1'b1;
            bus.out_x          <= x_next;
            bus.out_y          <= y_next;
            bus.out_alusel     <= bus.in_alusel;
            bus.out_store_data <= rs2_fwd;
            bus.out_pc         <= bus.in_pc;
            bus.out_rd         <= bus.in_rd;
            bus.out_wen        <= bus.in_wen;
            bus.out_is_load    <= bus.in_is_load;
        end else if (!bus.out_valid || bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
